// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if
//   Handshake bundle between N producers, the rr_mux_reg block and one consumer.
//   Signals:
//     mode      - 0 = manual select, 1 = round-robin
//     select    - channel index used in manual mode
//     in_data   - packed channel data, channel i at [i*WIDTH +: WIDTH]
//     in_valid  - per-channel valid
//     in_ready  - per-channel ready (one-hot or zero)
//     out_data  - registered output word
//     out_chan  - channel that produced out_data
//     out_valid - output register holds a word
//     out_ready - consumer accepts the word
//   Modports: master (producers/consumer side), slave (mux side).
interface rr_mux_reg_if #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
);
  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output mode, select, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  mode, select, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg
//   Registered N-channel multiplexer with valid/ready on every input and on
//   the output. Manual mode forwards the channel named by select; round-robin
//   mode grants the first valid channel after the last one served.
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - rr_mux_reg_if.slave handshake bundle
module rr_mux_reg #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_reg_if.slave  bus
);

  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_data_r;
  logic [SEL_W-1:0]     out_chan_r;
  logic [SEL_W-1:0]     last_r;

  logic                 load_en_s;
  logic                 grant_vld_s;
  logic [SEL_W-1:0]     grant_idx_s;
  logic [WIDTH-1:0]     chan_data_s [CHANNELS];

  // Channel reached by stepping 'step' positions past 'base', wrapping.
  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base,
                                              input int step);
    int sum_v;
    sum_v = (int'(base) + step) % CHANNELS;
    return sum_v[SEL_W-1:0];
  endfunction

  // Output register may take a new word when empty or draining this cycle.
  assign load_en_s = !out_valid_r || bus.out_ready;

  // Grant decision: manual select or round-robin scan starting after last_r.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    if (bus.mode == 1'b0) begin
      // Out-of-range select (non power-of-2 CHANNELS) simply grants nothing.
      if (int'(bus.select) < CHANNELS) begin
        if (bus.in_valid[bus.select]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = bus.select;
        end else begin
          grant_vld_s = 1'b0;
        end
      end else begin
        grant_vld_s = 1'b0;
      end
    end else begin
      // Highest priority is last_r+1, lowest is last_r itself.
      for (int k = CHANNELS; k >= 1; k--) begin
        if (bus.in_valid[rr_idx(last_r, k)]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = rr_idx(last_r, k);
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Per-channel data slices and one-hot ready; ready is forced low in reset.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan_data_s[i]  = bus.in_data[i*WIDTH +: WIDTH];
    assign bus.in_ready[i] = rst_n && load_en_s && grant_vld_s &&
                             (grant_idx_s == SEL_W'(i));
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
      last_r      <= SEL_W'(CHANNELS - 1);
    end else if (load_en_s) begin
      if (grant_vld_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= chan_data_s[grant_idx_s];
        out_chan_r  <= grant_idx_s;
        last_r      <= grant_idx_s;
      end else begin
        // Nothing to load: drop valid, keep data/chan for observability.
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_chan  = out_chan_r;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg
//   Directed bench for rr_mux_reg with a 4-channel and a 3-channel instance.
//   Stimulus pushes hand-computed expected words into per-instance queues;
//   monitors pop and compare whenever an output word is accepted.
module tb_rr_mux_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_reg_if #(.WIDTH(2), .CHANNELS(4)) ifa ();
  rr_mux_reg_if #(.WIDTH(2), .CHANNELS(3)) ifb ();

  rr_mux_reg #(.WIDTH(2), .CHANNELS(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  rr_mux_reg #(.WIDTH(2), .CHANNELS(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct {
    int         chan;
    logic [1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One stimulus cycle: drive inputs, check in_ready, queue the expected word.
  task automatic cyc(input bit on_b, input logic m, input logic [1:0] sel,
                     input logic [3:0] v, input logic [7:0] d, input logic ordy,
                     input logic [3:0] er, input string name);
    exp_t e;
    if (on_b) begin
      ifb.mode = m; ifb.select = sel; ifb.in_valid = v[2:0];
      ifb.in_data = d[5:0]; ifb.out_ready = ordy;
    end else begin
      ifa.mode = m; ifa.select = sel; ifa.in_valid = v;
      ifa.in_data = d; ifa.out_ready = ordy;
    end
    @(negedge clk);
    if (on_b) chk(name, 32'(ifb.in_ready), 32'(er[2:0]));
    else      chk(name, 32'(ifa.in_ready), 32'(er));
    for (int k = 0; k < 4; k++) begin
      if (er[k]) begin
        e.chan = k;
        e.data = d[2*k +: 2];
        if (on_b) qb.push_back(e);
        else      qa.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-channel instance.
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got chan %0d data %0h expected no word", ifa.out_chan, ifa.out_data);
      end else begin
        ea = qa.pop_front();
        chk("a_out_chan", 32'(ifa.out_chan), 32'(ea.chan));
        chk("a_out_data", 32'(ifa.out_data), 32'(ea.data));
      end
    end
  end

  // Monitor for the 3-channel instance.
  always @(negedge clk) begin
    if (ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got chan %0d data %0h expected no word", ifb.out_chan, ifb.out_data);
      end else begin
        eb = qb.pop_front();
        chk("b_out_chan", 32'(ifb.out_chan), 32'(eb.chan));
        chk("b_out_data", 32'(ifb.out_data), 32'(eb.data));
      end
    end
  end

  logic [3:0] rr_all [6];

  initial begin
    rr_all = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ifa.mode = 1'b0; ifa.select = 2'd0; ifa.in_valid = 4'd0; ifa.in_data = 8'd0; ifa.out_ready = 1'b1;
    ifb.mode = 1'b0; ifb.select = 2'd0; ifb.in_valid = 3'd0; ifb.in_data = 6'd0; ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_data",  32'(ifa.out_data),  32'd0);
    chk("rst_out_chan",  32'(ifa.out_chan),  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Manual mode: select 2, ch2 data = 2'b10.
    cyc(1'b0, 1'b0, 2'd2, 4'hF, 8'hE4, 1'b1, 4'b0100, "man_sel2_ready");
    chk("man_out_valid", 32'(ifa.out_valid), 32'd1);

    // Round-robin, all valid, continuing after channel 2.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 2'd0, 4'hF, 8'h1B, 1'b1, rr_all[i], "rr_all_ready");

    // Move last to 1, then sparse valid 1010 -> 3, 1, 3.
    cyc(1'b0, 1'b1, 2'd0, 4'b0010, 8'h6C, 1'b1, 4'b0010, "rr_ch1_ready");
    cyc(1'b0, 1'b1, 2'd0, 4'b1010, 8'h6C, 1'b1, 4'b1000, "rr_sparse_3a");
    cyc(1'b0, 1'b1, 2'd0, 4'b1010, 8'h6C, 1'b1, 4'b0010, "rr_sparse_1");
    cyc(1'b0, 1'b1, 2'd0, 4'b1010, 8'h6C, 1'b1, 4'b1000, "rr_sparse_3b");

    // Backpressure: ch3 word (2'b01) held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 2'd0, 4'hF, 8'h6C, 1'b0, 4'b0000, "bp_ready");
      chk("bp_hold_valid", 32'(ifa.out_valid), 32'd1);
      chk("bp_hold_chan",  32'(ifa.out_chan),  32'd3);
      chk("bp_hold_data",  32'(ifa.out_data),  32'd1);
    end
    // Drain and load together: next after last=3 is channel 0.
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 8'h6C, 1'b1, 4'b0001, "bp_resume_ready");
    chk("no_bubble_valid", 32'(ifa.out_valid), 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 4'h0, 8'h6C, 1'b1, 4'b0000, "idle_ready");
    chk("idle_out_valid", 32'(ifa.out_valid), 32'd0);

    // Reset while a word is held.
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 8'h1B, 1'b1, 4'b0010, "pre_rst_ready");
    ifa.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("midrst_out_data",  32'(ifa.out_data),  32'd0);
    chk("midrst_out_chan",  32'(ifa.out_chan),  32'd0);
    ifa.out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(ifa.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 8'h1B, 1'b1, 4'b0001, "post_rst_first");
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 8'h1B, 1'b1, 4'b0010, "post_rst_second");
    cyc(1'b0, 1'b1, 2'd0, 4'h0, 8'h1B, 1'b1, 4'b0000, "a_drain_ready");

    // Three channels: ch0=11, ch1=01, ch2=10.
    cyc(1'b1, 1'b0, 2'd1, 4'b0111, 8'h27, 1'b1, 4'b0010, "b_man1_ready");
    cyc(1'b1, 1'b0, 2'd3, 4'b0111, 8'h27, 1'b1, 4'b0000, "b_oor_ready");
    chk("b_oor_out_valid", 32'(ifb.out_valid), 32'd0);
    cyc(1'b1, 1'b1, 2'd3, 4'b0101, 8'h27, 1'b1, 4'b0100, "b_rr2_ready");
    cyc(1'b1, 1'b1, 2'd3, 4'b0101, 8'h27, 1'b1, 4'b0001, "b_rr0_ready");
    cyc(1'b1, 1'b1, 2'd0, 4'b0000, 8'h27, 1'b1, 4'b0000, "b_drain_ready");

    @(negedge clk);
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Registered, parametrised N-channel multiplexer with a valid/ready handshake on every input channel and on the output. It has two selection modes: a manual mode driven by an external select, and a round-robin mode with fair arbitration among valid channels. It sits between several data producers and a single consumer and replaces unregistered select-driven muxes where backpressure and fairness are needed.

## Interface
- WIDTH, 2, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- SEL_W, $clog2(CHANNELS), width of select/channel index (derived; not overridden)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- mode  input  1  0 = manual select, 1 = round-robin
- select  input  SEL_W  channel index used in manual mode
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle
- out_data  output  WIDTH  registered data
- out_chan  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  out_data/out_chan hold a word
- out_ready  input  1  consumer accepts the word when high with out_valid

## Operation
- Output stage: one register holding out_data, out_chan and out_valid.
- load_en = !out_valid || out_ready (register empty or draining this cycle).
- Grant selection (combinational, one channel g or none):
  - mode 0: g = select if select < CHANNELS and in_valid[select]; otherwise none.
  - mode 1: scan channels last+1, last+2, … wrapping modulo CHANNELS; g = first with in_valid high; none if in_valid == 0.
- in_ready[i] = load_en && (grant exists) && (i == g); all other bits 0.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data slice g, out_chan <= g, out_valid <= 1, last <= g.
- When load_en is high and no grant exists: out_valid <= 0 on the edge. out_data and out_chan hold their previous values.
- When load_en is low: the output register holds, all in_ready are 0, and last is unchanged.
- The last pointer updates on every transfer in both modes. Switching from mode 0 to mode 1 therefore continues fairly from the last served channel.
- A change to mode or select affects only the next grant decision; a word already held in the output register is never altered.
- in_ready depends on in_valid. Producers must not make in_valid depend on in_ready.
- Data is passed through unmodified; no width conversion.

## Timing
- Reset values (asynchronous on rst_n low, released synchronously with clk): out_valid = 0, out_data = 0, out_chan = 0, last = CHANNELS-1. Channel 0 therefore has first priority in round-robin.
- Reset mid-transfer: any held word is discarded; out_valid drops immediately and in_ready goes to 0 while rst_n is low.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready is held high and some channel is valid.
- Simultaneous drain and load in the same cycle (out_valid && out_ready && new grant) is supported with no bubble.
- Round-robin fairness: with all channels continuously valid and no backpressure, each channel is granted exactly once every CHANNELS cycles.
- Out-of-range select (only possible when CHANNELS is not a power of 2): no grant and no transfer. Not an error.

## Test plan
- Reset: assert rst_n = 0 mid-stream with out_valid = 1 -> out_valid, out_data and out_chan read 0 immediately and all in_ready = 0; after release, the first round-robin grant goes to channel 0.
- Manual mode, CHANNELS=4, WIDTH=2: select=2, in_valid=4'b1111, in_data ch2 = 2'b10, out_ready=1 -> in_ready=4'b0100; next cycle out_data=2'b10, out_chan=2, out_valid=1.
- Round-robin, all valid, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; exactly one in_ready bit high each cycle.
- Round-robin, in_valid=4'b1010, last=1 -> grant 3, then 1, then 3.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data and out_chan stable, in_ready=0, last unchanged. When out_ready returns to 1, the next grant loads in the same cycle the held word drains.
- CHANNELS=3 in manual mode with select=3 -> in_ready=0 and out_valid falls to 0 after draining. Switching to mode 1 then grants the next valid channel after last.
